// File: rtl/shift_add_multiplier_8bit_pkg.sv
// Shared types and sizing for the shift-and-add multiplier.
//   WIDTH  : operand width (the ripple adder is fixed at 8 bits)
//   CNT_W  : iteration counter width, must be able to hold WIDTH
//   PROD_W : product width
package mult_pkg;
   localparam int WIDTH  = 8;
   localparam int CNT_W  = 4;
   localparam int PROD_W = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;
endpackage

// File: rtl/shift_add_multiplier_8bit_if.sv
// Start/busy/done handshake bundle for the multiplier.
//   start        : request, sampled only while the multiplier is idle
//   multiplicand : operand A, captured with an accepted start
//   multiplier   : operand B, captured with an accepted start
//   busy         : high while an operation is in flight (CALC and DONE)
//   done         : one-cycle pulse, product valid
//   product      : A*B, held until the next accepted start
interface shift_add_multiplier_8bit_if import mult_pkg::*; ();
   logic              start;
   logic [WIDTH-1:0]  multiplicand;
   logic [WIDTH-1:0]  multiplier;
   logic              busy;
   logic              done;
   logic [PROD_W-1:0] product;

   modport master (output start, multiplicand, multiplier,
                   input  busy, done, product);
   modport slave  (input  start, multiplicand, multiplier,
                   output busy, done, product);
endinterface

// File: rtl/shift_add_multiplier_8bit_adder.sv
// 8-bit unsigned adder shared by every iteration of the multiplier.
//   numberA : addend (running upper half of the product)
//   numberB : addend (multiplicand or zero)
//   result  : 8-bit sum
//   cout    : carry out
module Adder_8bit (
   input  logic [7:0] numberA,
   input  logic [7:0] numberB,
   output logic [7:0] result,
   output logic       cout
);
   assign {cout, result} = {1'b0, numberA} + {1'b0, numberB};
endmodule

// File: rtl/shift_add_multiplier_8bit.sv
// Sequential 8x8 unsigned radix-2 shift-and-add multiplier, one partial
// product per clock through a single shared 8-bit adder.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; aborts any operation in flight
//   bus   : start/operands in, busy/done/product out (slave modport)
module shift_add_multiplier_8bit #(
   parameter int WIDTH = mult_pkg::WIDTH,
   parameter int CNT_W = mult_pkg::CNT_W
) (
   input  logic                        clk,
   input  logic                        reset,
   shift_add_multiplier_8bit_if.slave  bus
);
   import mult_pkg::*;

   if (WIDTH != 8) begin : g_width_chk
      $error("shift_add_multiplier_8bit: WIDTH must be 8 to match Adder_8bit");
   end
   if ((1 << CNT_W) <= WIDTH) begin : g_cnt_chk
      $error("shift_add_multiplier_8bit: CNT_W too small to hold WIDTH");
   end

   mult_state_t        r_state, w_next_state;
   logic [WIDTH-1:0]   r_m;       // multiplicand
   logic [WIDTH-1:0]   r_acc;     // upper half of running product
   logic [WIDTH-1:0]   r_q;       // lower half / remaining multiplier bits
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [2*WIDTH-1:0] r_product;

   logic [WIDTH-1:0]   w_addend;
   logic [WIDTH-1:0]   w_sum;
   logic               w_cout;
   logic               w_last;

   assign w_addend = r_q[0] ? r_m : '0;
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

   Adder_8bit u_adder (
      .numberA (r_acc),
      .numberB (w_addend),
      .result  (w_sum),
      .cout    (w_cout)
   );

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next_state = CALC;
         CALC:    if (w_last)    w_next_state = DONE;
         DONE:                   w_next_state = IDLE;
         default:                w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_m       <= '0;
         r_acc     <= '0;
         r_q       <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_m    <= bus.multiplicand;
                  r_q    <= bus.multiplier;
                  r_acc  <= '0;
                  r_cnt  <= '0;
                  r_busy <= 1'b1;
               end
            end
            CALC: begin
               // Carry lands in ACC[7]; sum LSB shifts into the top of Q.
               r_acc <= {w_cout, w_sum[WIDTH-1:1]};
               r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  // Capture the final shifted value directly so product is
                  // already valid in the cycle done is high.
                  r_product <= {w_cout, w_sum, r_q[WIDTH-1:1]};
                  r_done    <= 1'b1;
               end
            end
            DONE: begin
               r_done <= 1'b0;
               r_busy <= 1'b0;
            end
            default: begin
               r_done <= 1'b0;
               r_busy <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.product = r_product;
endmodule
